// File: rtl/servive_pkg.sv
// servive_pkg: shared types and helpers for the servive memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY, DONE)
//   width_of()  : clog2-based index width, never less than one bit
package servive_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // Bits needed to index n items; a single item still gets one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/servive_rr_picker.sv
// servive_rr_picker: combinational round-robin winner selection.
//   i_req   : request vector, one bit per master
//   i_last  : index of the previous winner
//   o_valid : at least one request is set
//   o_idx   : first requesting master found searching from i_last+1 upward
module servive_rr_picker
  import servive_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int GW          = width_of(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [GW-1:0]          i_last,
  output logic                   o_valid,
  output logic [GW-1:0]          o_idx
);

  // Walk offsets from farthest to nearest so the nearest hit after i_last
  // is the one left standing.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      o_valid = i_req[(int'(i_last) + off) % NUM_MASTERS] ? 1'b1 : o_valid;
      o_idx   = i_req[(int'(i_last) + off) % NUM_MASTERS]
              ? GW'((int'(i_last) + off) % NUM_MASTERS) : o_idx;
    end
  end

endmodule

// File: rtl/servive_mem_arbiter.sv
// servive_mem_arbiter: round-robin Wishbone arbiter sharing one slave port
// between NUM_MASTERS SERV cores, one transaction at a time, with a watchdog
// that completes a transaction the slave never acks.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_wb_m_*                : packed master requests (master k at slice k)
//   o_wb_m_rdt, o_wb_m_ack  : read data broadcast, one-hot ack to the owner
//   o_wb_s_*, i_wb_s_*      : shared slave port
//   o_grant                 : current or last owner index
//   o_timeout               : one-cycle pulse when the watchdog completes a transfer
module servive_mem_arbiter
  import servive_pkg::*;
#(
  parameter int          NUM_MASTERS = 4,
  parameter int          AW          = 32,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] TIMEOUT_RDT = 32'hFFFF_FFFF
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_MASTERS*AW-1:0]   i_wb_m_adr,
  input  logic [NUM_MASTERS*32-1:0]   i_wb_m_dat,
  input  logic [NUM_MASTERS*4-1:0]    i_wb_m_sel,
  input  logic [NUM_MASTERS-1:0]      i_wb_m_we,
  input  logic [NUM_MASTERS-1:0]      i_wb_m_cyc,
  output logic [31:0]                 o_wb_m_rdt,
  output logic [NUM_MASTERS-1:0]      o_wb_m_ack,
  output logic [AW-1:0]               o_wb_s_adr,
  output logic [31:0]                 o_wb_s_dat,
  output logic [3:0]                  o_wb_s_sel,
  output logic                        o_wb_s_we,
  output logic                        o_wb_s_cyc,
  input  logic [31:0]                 i_wb_s_rdt,
  input  logic                        i_wb_s_ack,
  output logic [$clog2(NUM_MASTERS)-1:0] o_grant,
  output logic                        o_timeout
);

  localparam int GW = width_of(NUM_MASTERS);
  localparam int TW = width_of(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX = '1;
  localparam logic [TW-1:0] TIMER_LIM = TW'(TIMEOUT);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last;
  logic [TW-1:0] r_timer;
  logic          w_pick_valid;
  logic [GW-1:0] w_pick_idx;
  logic          w_cyc_granted;
  logic          w_wdog;

  servive_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .GW          (GW)
  ) u_picker (
    .i_req   (i_wb_m_cyc),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Slave request always follows the current owner; only cyc is qualified.
  assign o_wb_s_adr    = i_wb_m_adr[int'(r_grant)*AW +: AW];
  assign o_wb_s_dat    = i_wb_m_dat[int'(r_grant)*32 +: 32];
  assign o_wb_s_sel    = i_wb_m_sel[int'(r_grant)*4 +: 4];
  assign o_wb_s_we     = i_wb_m_we[r_grant];
  assign o_grant       = r_grant;
  assign w_cyc_granted = i_wb_m_cyc[r_grant];
  assign w_wdog        = (TIMEOUT != 0) && (r_timer == TIMER_LIM);

  // Next-state and response logic; a slave ack outranks the watchdog.
  always_comb begin
    w_state_nxt = r_state;
    o_wb_m_ack  = '0;
    o_wb_s_cyc  = 1'b0;
    o_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = w_pick_valid ? BUSY : IDLE;
      end
      BUSY: begin
        o_wb_s_cyc = 1'b1;
        if (!w_cyc_granted) begin
          // Owner withdrew mid-transfer: close out without an ack.
          w_state_nxt = DONE;
        end else if (i_wb_s_ack) begin
          o_wb_m_ack[r_grant] = 1'b1;
          w_state_nxt         = DONE;
        end else if (w_wdog) begin
          o_wb_m_ack[r_grant] = 1'b1;
          o_timeout           = 1'b1;
          w_state_nxt         = DONE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    o_wb_m_rdt = o_timeout ? TIMEOUT_RDT : i_wb_s_rdt;
  end

  // State, owner and watchdog timer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= GW'(NUM_MASTERS - 1);
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_pick_valid) begin
        r_grant <= w_pick_idx;
        r_last  <= w_pick_idx;
        r_timer <= '0;
      end else if (r_state == BUSY && r_timer != TIMER_MAX) begin
        r_timer <= r_timer + TW'(1);
      end else begin
        r_timer <= r_timer;
      end
    end
  end

endmodule

// File: tb/tb_servive_mem_arbiter.sv
// Directed self-checking bench for servive_mem_arbiter (4 masters, TIMEOUT=8).
module tb_servive_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [N*AW-1:0]   i_wb_m_adr;
  logic [N*32-1:0]   i_wb_m_dat;
  logic [N*4-1:0]    i_wb_m_sel;
  logic [N-1:0]      i_wb_m_we;
  logic [N-1:0]      i_wb_m_cyc;
  logic [31:0]       o_wb_m_rdt;
  logic [N-1:0]      o_wb_m_ack;
  logic [AW-1:0]     o_wb_s_adr;
  logic [31:0]       o_wb_s_dat;
  logic [3:0]        o_wb_s_sel;
  logic              o_wb_s_we;
  logic              o_wb_s_cyc;
  logic [31:0]       i_wb_s_rdt;
  logic              i_wb_s_ack;
  logic [1:0]        o_grant;
  logic              o_timeout;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;

  servive_mem_arbiter #(
    .NUM_MASTERS (N),
    .AW          (AW),
    .TIMEOUT     (8),
    .TIMEOUT_RDT (32'hFFFF_FFFF)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wb_m_adr (i_wb_m_adr),
    .i_wb_m_dat (i_wb_m_dat),
    .i_wb_m_sel (i_wb_m_sel),
    .i_wb_m_we  (i_wb_m_we),
    .i_wb_m_cyc (i_wb_m_cyc),
    .o_wb_m_rdt (o_wb_m_rdt),
    .o_wb_m_ack (o_wb_m_ack),
    .o_wb_s_adr (o_wb_s_adr),
    .o_wb_s_dat (o_wb_s_dat),
    .o_wb_s_sel (o_wb_s_sel),
    .o_wb_s_we  (o_wb_s_we),
    .o_wb_s_cyc (o_wb_s_cyc),
    .i_wb_s_rdt (i_wb_s_rdt),
    .i_wb_s_ack (i_wb_s_ack),
    .o_grant    (o_grant),
    .o_timeout  (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are read well after the edge.
  task automatic step();
    @(posedge i_clk);
    #2;
    cyc_cnt++;
  endtask

  task automatic set_m(input int k, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
    i_wb_m_adr[k*AW +: AW] = adr;
    i_wb_m_dat[k*32 +: 32] = dat;
    i_wb_m_sel[k*4 +: 4]   = sel;
    i_wb_m_we[k]           = we;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  initial begin
    int start_prev;
    int start_now;
    i_rst_n    = 1'b0;
    i_wb_m_adr = '0;
    i_wb_m_dat = '0;
    i_wb_m_sel = '0;
    i_wb_m_we  = '0;
    i_wb_m_cyc = '0;
    i_wb_s_rdt = '0;
    i_wb_s_ack = 1'b0;
    start_prev = 0;
    for (int k = 0; k < N; k++) set_m(k, 32'h1000 * k, 32'h0, 4'hF, 1'b0);

    // Reset state
    #3;
    chk("rst_s_cyc", 64'(o_wb_s_cyc), 64'd0);
    chk("rst_ack",   64'(o_wb_m_ack), 64'd0);
    chk("rst_grant", 64'(o_grant),    64'd0);
    chk("rst_tmo",   64'(o_timeout),  64'd0);
    do_reset();

    // Single master: master 2 reads 0x100, slave acks two cycles after cyc
    set_m(2, 32'h100, 32'h0, 4'hF, 1'b0);
    i_wb_m_cyc = 4'b0100;
    #1 chk("sm_idle_s_cyc", 64'(o_wb_s_cyc), 64'd0);
    step();
    chk("sm_busy_s_cyc", 64'(o_wb_s_cyc), 64'd1);
    chk("sm_grant",      64'(o_grant),    64'd2);
    chk("sm_s_adr",      64'(o_wb_s_adr), 64'h100);
    chk("sm_noack",      64'(o_wb_m_ack), 64'd0);
    step();
    i_wb_s_ack = 1'b1;
    i_wb_s_rdt = 32'hDEADBEEF;
    #1;
    chk("sm_ack",   64'(o_wb_m_ack), 64'b0100);
    chk("sm_rdt",   64'(o_wb_m_rdt), 64'hDEADBEEF);
    chk("sm_grant2",64'(o_grant),    64'd2);
    step();
    i_wb_s_ack = 1'b0;
    i_wb_m_cyc = 4'b0000;
    #1;
    chk("sm_done_s_cyc", 64'(o_wb_s_cyc), 64'd0);
    chk("sm_done_ack",   64'(o_wb_m_ack), 64'd0);
    step();

    // Write mux: master 3 writes while master 1 pends (last owner was 2)
    set_m(3, 32'h40, 32'h1234_5678, 4'b0011, 1'b1);
    set_m(1, 32'h80, 32'hAAAA_5555, 4'b1111, 1'b0);
    i_wb_m_cyc = 4'b1010;
    step();
    chk("wr_grant", 64'(o_grant),    64'd3);
    chk("wr_adr",   64'(o_wb_s_adr), 64'h40);
    chk("wr_dat",   64'(o_wb_s_dat), 64'h1234_5678);
    chk("wr_sel",   64'(o_wb_s_sel), 64'b0011);
    chk("wr_we",    64'(o_wb_s_we),  64'd1);
    chk("wr_cyc",   64'(o_wb_s_cyc), 64'd1);
    step();
    chk("wr_hold_adr", 64'(o_wb_s_adr), 64'h40);
    i_wb_s_ack = 1'b1;
    #1 chk("wr_ack", 64'(o_wb_m_ack), 64'b1000);
    step();
    i_wb_s_ack = 1'b0;
    i_wb_m_cyc = 4'b0010;
    step();
    step();
    chk("wr_next_grant", 64'(o_grant),    64'd1);
    chk("wr_next_adr",   64'(o_wb_s_adr), 64'h80);
    chk("wr_next_we",    64'(o_wb_s_we),  64'd0);
    i_wb_s_ack = 1'b1;
    #1 chk("wr_next_ack", 64'(o_wb_m_ack), 64'b0010);
    step();
    i_wb_s_ack = 1'b0;
    i_wb_m_cyc = 4'b0000;
    step();

    // Fairness: all masters request, slave acks on the second BUSY cycle
    do_reset();
    i_wb_m_cyc = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      for (int w = 0; w < 10 && !o_wb_s_cyc; w++) step();
      chk("fair_wait", 64'(o_wb_s_cyc), 64'd1);
      start_now = cyc_cnt;
      chk("fair_grant", 64'(o_grant), 64'(g % N));
      if (g > 0) chk("fair_spacing", 64'(start_now - start_prev), 64'd4);
      start_prev = start_now;
      step();
      i_wb_s_ack = 1'b1;
      i_wb_s_rdt = 32'(g);
      #1 chk("fair_ack", 64'(o_wb_m_ack), 64'(4'b0001 << (g % N)));
      step();
      i_wb_s_ack = 1'b0;
    end
    i_wb_m_cyc = 4'b0000;
    step();

    // Timeout: masters 0 and 1 request, slave never acks (last owner 3)
    i_wb_m_cyc = 4'b0011;
    step();
    chk("to_grant", 64'(o_grant), 64'd0);
    for (int c = 0; c < 7; c++) step();
    chk("to_early_ack", 64'(o_wb_m_ack), 64'd0);
    chk("to_early_tmo", 64'(o_timeout),  64'd0);
    step();
    chk("to_ack",   64'(o_wb_m_ack), 64'b0001);
    chk("to_rdt",   64'(o_wb_m_rdt), 64'hFFFF_FFFF);
    chk("to_pulse", 64'(o_timeout),  64'd1);
    step();
    i_wb_m_cyc = 4'b0010;
    #1;
    chk("to_pulse_end", 64'(o_timeout),  64'd0);
    chk("to_done_cyc",  64'(o_wb_s_cyc), 64'd0);
    step();
    step();
    chk("to_next_grant", 64'(o_grant), 64'd1);

    // Simultaneous: slave ack lands on the watchdog cycle
    for (int c = 0; c < 8; c++) step();
    i_wb_s_ack = 1'b1;
    i_wb_s_rdt = 32'hCAFE_F00D;
    #1;
    chk("sim_ack", 64'(o_wb_m_ack), 64'b0010);
    chk("sim_rdt", 64'(o_wb_m_rdt), 64'hCAFE_F00D);
    chk("sim_tmo", 64'(o_timeout),  64'd0);
    step();
    i_wb_s_ack = 1'b0;
    i_wb_m_cyc = 4'b0000;
    step();

    // Reset mid-BUSY (last owner 1, so master 2 wins)
    i_wb_m_cyc = 4'b0100;
    step();
    chk("rb_busy", 64'(o_wb_s_cyc), 64'd1);
    i_wb_s_ack = 1'b1;
    i_rst_n = 1'b0;
    #1;
    chk("rb_s_cyc", 64'(o_wb_s_cyc), 64'd0);
    chk("rb_ack",   64'(o_wb_m_ack), 64'd0);
    chk("rb_grant", 64'(o_grant),    64'd0);
    step();
    i_rst_n    = 1'b1;
    i_wb_s_ack = 1'b0;
    i_wb_m_cyc = 4'b0101;
    step();
    chk("rb_first_grant", 64'(o_grant), 64'd0);
    i_wb_s_ack = 1'b1;
    #1 chk("rb_first_ack", 64'(o_wb_m_ack), 64'b0001);
    step();
    i_wb_s_ack = 1'b0;
    i_wb_m_cyc = 4'b0000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
